// File: rtl/alu_op_pkg.sv
// Shared op-code map, decode constants and FSM state type for the ALU-select sequencer.
// Op codes are 4 bits wide; wider alu_op ports zero-extend them.
package alu_op_pkg;

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRL  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_MULH = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_REM  = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd11;
    localparam logic [3:0] OP_SRA  = 4'd12;
    localparam logic [3:0] OP_SLTU = 4'd13;
    localparam logic [3:0] OP_DIVU = 4'd14;
    localparam logic [3:0] OP_REMU = 4'd15;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_HOLD} state_t;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) ||
               (op == OP_REM) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational RV32IM instruction -> 4-bit ALU op decode; zero latency, no flow control.
// Anything that is not an uncompressed R/I arithmetic instruction decodes to ADD.
module alu_op_decode
    import alu_op_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [3:0]  o_op
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_alt;
    logic       w_unused_bits;

    assign w_opc         = i_instr[6:0];
    assign w_f3          = i_instr[14:12];
    assign w_f7          = i_instr[31:25];
    assign w_alt         = i_instr[30];
    assign w_unused_bits = ^{i_instr[24:15], i_instr[11:7]};

    // OPC_R/OPC_I both end in 2'b11, so compressed encodings fall through to ADD.
    always_comb begin
        o_op = OP_ADD;
        if (w_opc == OPC_R && w_f7 == FUNCT7_M) begin
            case (w_f3)
                3'b000:                 o_op = OP_MUL;
                3'b001, 3'b010, 3'b011: o_op = OP_MULH;
                3'b100:                 o_op = OP_DIV;
                3'b101:                 o_op = OP_DIVU;
                3'b110:                 o_op = OP_REM;
                default:                o_op = OP_REMU;
            endcase
        end else if (w_opc == OPC_R || w_opc == OPC_I) begin
            case (w_f3)
                3'b000:  o_op = (w_opc == OPC_R && w_alt) ? OP_SUB : OP_ADD;
                3'b001:  o_op = OP_SLL;
                3'b010:  o_op = OP_SLT;
                3'b011:  o_op = OP_SLTU;
                3'b100:  o_op = OP_XOR;
                3'b101:  o_op = w_alt ? OP_SRA : OP_SRL;
                3'b110:  o_op = OP_OR;
                default: o_op = OP_AND;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU-op decoder/sequencer: single-cycle ops valid 1 cycle after accept, MUL/DIV ops after LAT+1.
// Result holds until out_ready; in_ready follows out_ready in HOLD and is forced low by flush.
module alu_op_sequencer
    import alu_op_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            flush,
    output logic [OP_W-1:0] alu_op,
    output logic            alu_start,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_t           r_state;
    logic [3:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start;
    logic             r_busy;
    logic             r_out_valid;
    logic [3:0]       w_dec_op;
    logic             w_accept;

    alu_op_decode u_decode (
        .i_instr (instr),
        .o_op    (w_dec_op)
    );

    assign in_ready = !flush && ((r_state == ST_IDLE) || (r_state == ST_HOLD && out_ready));
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_ADD;
            r_cnt       <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (flush) begin
                r_state     <= ST_IDLE;
                r_cnt       <= '0;
                r_busy      <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_HOLD: begin
                        if (w_accept) begin
                            r_op <= w_dec_op;
                            if (is_multi(w_dec_op)) begin
                                r_state     <= ST_EXEC;
                                r_cnt       <= is_mul(w_dec_op) ? MUL_LOAD : DIV_LOAD;
                                r_start     <= 1'b1;
                                r_busy      <= 1'b1;
                                r_out_valid <= 1'b0;
                            end else begin
                                r_state     <= ST_HOLD;
                                r_busy      <= 1'b0;
                                r_out_valid <= 1'b1;
                            end
                        end else if (r_state == ST_HOLD && out_ready) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end
                    ST_EXEC: begin
                        // Counter starts at LAT-1, so EXEC lasts exactly LAT cycles.
                        if (r_cnt == '0) begin
                            r_state     <= ST_HOLD;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign alu_op    = OP_W'(r_op);
    assign alu_start = r_start;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: transaction-age reference model checked every cycle, plus directed literal checks.
module tb_alu_op_sequencer;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h4040D193;
    localparam logic [31:0] I_CMP  = 32'h00004501;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_DIV  = 32'h0220C1B3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic [3:0]  alu_op;
    logic        alu_start;
    logic        busy;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    alu_op_sequencer #(.OP_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .flush     (flush),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction-set rules.
    function automatic logic [3:0] ref_op(input logic [31:0] w);
        logic [2:0] f3;
        f3 = w[14:12];
        if (w[1:0] != 2'b11) return 4'd2;
        if (w[6:0] == 7'h33 && w[31:25] == 7'h01) begin
            case (f3)
                3'd0:             return 4'd7;
                3'd1, 3'd2, 3'd3: return 4'd8;
                3'd4:             return 4'd9;
                3'd5:             return 4'd14;
                3'd6:             return 4'd10;
                default:          return 4'd15;
            endcase
        end
        if (w[6:0] != 7'h33 && w[6:0] != 7'h13) return 4'd2;
        case (f3)
            3'd0:    return (w[6:0] == 7'h33 && w[30]) ? 4'd11 : 4'd2;
            3'd1:    return 4'd0;
            3'd2:    return 4'd6;
            3'd3:    return 4'd13;
            3'd4:    return 4'd5;
            3'd5:    return w[30] ? 4'd12 : 4'd1;
            3'd6:    return 4'd4;
            default: return 4'd3;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        if (op == 4'd7 || op == 4'd8) return MUL_LAT;
        if (op == 4'd9 || op == 4'd10 || op == 4'd14 || op == 4'd15) return DIV_LAT;
        return 0;
    endfunction

    // Model: the in-flight transaction, its latency and how many cycles ago it was accepted.
    bit         m_has;
    logic [3:0] m_op;
    int         m_age;
    int         m_lat;

    function automatic logic e_ov();    return m_has && (m_age > m_lat); endfunction
    function automatic logic e_busy();  return m_has && (m_age <= m_lat); endfunction
    function automatic logic e_start(); return m_has && (m_lat > 0) && (m_age == 1); endfunction
    function automatic logic e_rdy();   return !flush && (!m_has || (e_ov() && out_ready)); endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_has <= 1'b0;
            m_op  <= 4'd2;
            m_age <= 0;
            m_lat <= 0;
        end else if (flush) begin
            m_has <= 1'b0;
        end else if (in_valid && e_rdy()) begin
            m_has <= 1'b1;
            m_op  <= ref_op(instr);
            m_lat <= lat_of(ref_op(instr));
            m_age <= 1;
        end else if (e_ov() && out_ready) begin
            m_has <= 1'b0;
        end else if (m_has) begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_alu_op",    alu_op,    m_op);
            chk("m_busy",      busy,      e_busy());
            chk("m_alu_start", alu_start, e_start());
            chk("m_out_valid", out_valid, e_ov());
            chk("m_in_ready",  in_ready,  e_rdy());
        end
    end

    task automatic drive(input logic iv, input logic [31:0] ins, input logic fl, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = iv;
        instr     = ins;
        flush     = fl;
        out_ready = ordy;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            1: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            2: begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
            3: w[6:0] = 7'h13;
            4: w[1:0] = 2'($urandom_range(0, 2));
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b0;

        chk("ref_add",  ref_op(I_ADD),  4'd2);
        chk("ref_sub",  ref_op(I_SUB),  4'd11);
        chk("ref_srai", ref_op(I_SRAI), 4'd12);
        chk("ref_cmp",  ref_op(I_CMP),  4'd2);
        chk("ref_mul",  ref_op(I_MUL),  4'd7);
        chk("ref_div",  ref_op(I_DIV),  4'd9);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_alu_op", alu_op, 4'd2);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_alu_start", alu_start, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        // add then sub back to back
        drive(1'b1, I_ADD, 1'b0, 1'b1);
        drive(1'b1, I_SUB, 1'b0, 1'b1);
        @(negedge clk);
        chk("b2b_op0", alu_op, 4'd2);
        chk("b2b_ov0", out_valid, 1'b1);
        chk("b2b_busy0", busy, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("b2b_op1", alu_op, 4'd11);
        chk("b2b_ov1", out_valid, 1'b1);
        chk("b2b_busy1", busy, 1'b0);

        // srai then compressed
        drive(1'b1, I_SRAI, 1'b0, 1'b1);
        drive(1'b1, I_CMP, 1'b0, 1'b1);
        @(negedge clk);
        chk("srai_op", alu_op, 4'd12);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("cmp_op", alu_op, 4'd2);
        drive(1'b0, '0, 1'b0, 1'b1);

        // mul: 3 EXEC cycles, result on cycle 4
        drive(1'b1, I_MUL, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            chk($sformatf("mul_busy_c%0d", k), busy, (k <= 3));
            chk($sformatf("mul_start_c%0d", k), alu_start, (k == 1));
            chk($sformatf("mul_ov_c%0d", k), out_valid, (k == 4));
            chk($sformatf("mul_inrdy_c%0d", k), in_ready, (k > 3));
            if (k <= 4) chk($sformatf("mul_op_c%0d", k), alu_op, 4'd7);
        end

        // div with 5 stalled result cycles
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            chk($sformatf("div_busy_c%0d", k), busy, (k <= 8));
            chk($sformatf("div_ov_c%0d", k), out_valid, (k >= 9));
            chk($sformatf("div_op_c%0d", k), alu_op, 4'd9);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("div_release_ov", out_valid, 1'b0);
        chk("div_release_inrdy", in_ready, 1'b1);

        // flush in 4th EXEC cycle of div, with a competing in_valid
        drive(1'b1, I_DIV, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b1, I_ADD, 1'b1, 1'b1);
        @(negedge clk);
        chk("flush_inrdy", in_ready, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush_busy", busy, 1'b0);
        chk("flush_ov", out_valid, 1'b0);
        chk("flush_start", alu_start, 1'b0);
        chk("flush_inrdy_after", in_ready, 1'b1);
        drive(1'b1, I_ADD, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_flush_ov", out_valid, 1'b1);
        chk("post_flush_op", alu_op, 4'd2);

        // asynchronous reset mid-EXEC
        drive(1'b1, I_DIV, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_op", alu_op, 4'd2);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ov", out_valid, 1'b0);
        chk("arst_start", alu_start, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arst_inrdy", in_ready, 1'b1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 6), gen_instr(),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7));
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
